mc_control: RTL and testbench

//  Multi-cycle sequencer for the 31-instruction MIPS datapath; a drop-in alternative to the single-cycle Control unit.

---
 rtl/mc_control.sv | 198 +++++++++++++++++++
 tb/tb_mc_control.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multi-cycle sequencer for the 31-instruction MIPS datapath: latches the decoded op,
// walks IF/ID/EX/MEM/WB, drives PC/RF/DMEM strobes, mux selects and ALU code, counts retirements.
module mc_control #(
  parameter int RETIRE_W = 32,
  parameter int MEM_TO   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [30:0]         op,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                im_r,
  output logic                pc_we,
  output logic                rf_we,
  output logic                dm_cs,
  output logic                dm_r,
  output logic                dm_w,
  output logic [8:0]          m,
  output logic [3:0]          aluc,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired,
  output logic                illegal,
  output logic                mem_err
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam int OP_ADD   = 0;
  localparam int OP_ADDU  = 1;
  localparam int OP_SUB   = 2;
  localparam int OP_SUBU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_OR    = 5;
  localparam int OP_XOR   = 6;
  localparam int OP_NOR   = 7;
  localparam int OP_SLT   = 8;
  localparam int OP_SLTU  = 9;
  localparam int OP_SLL   = 10;
  localparam int OP_SRL   = 11;
  localparam int OP_SRA   = 12;
  localparam int OP_SLLV  = 13;
  localparam int OP_SRLV  = 14;
  localparam int OP_SRAV  = 15;
  localparam int OP_JR    = 16;
  localparam int OP_ADDI  = 17;
  localparam int OP_ADDIU = 18;
  localparam int OP_ANDI  = 19;
  localparam int OP_ORI   = 20;
  localparam int OP_XORI  = 21;
  localparam int OP_LW    = 22;
  localparam int OP_SW    = 23;
  localparam int OP_BEQ   = 24;
  localparam int OP_BNE   = 25;
  localparam int OP_SLTI  = 26;
  localparam int OP_SLTIU = 27;
  localparam int OP_LUI   = 28;
  localparam int OP_J     = 29;
  localparam int OP_JAL   = 30;

  state_t      cur;
  logic [30:0] ir_op;
  logic [31:0] wait_cnt;
  logic        onehot;
  logic [30:0] dec;
  logic        is_lw;
  logic        is_sw;
  logic        is_ctl;
  logic        timeout;
  logic [8:0]  m_dec;

  function automatic logic [3:0] alu_code(input logic [30:0] d);
    logic [3:0] c;
    c = 4'b0000;
    if (d[OP_ADD]  | d[OP_ADDI])                 c = 4'b0010;
    if (d[OP_SUBU])                              c = 4'b0001;
    if (d[OP_SUB]  | d[OP_BEQ] | d[OP_BNE])      c = 4'b0011;
    if (d[OP_AND]  | d[OP_ANDI])                 c = 4'b0100;
    if (d[OP_OR]   | d[OP_ORI])                  c = 4'b0101;
    if (d[OP_XOR]  | d[OP_XORI])                 c = 4'b0110;
    if (d[OP_NOR])                               c = 4'b0111;
    if (d[OP_LUI])                               c = 4'b1000;
    if (d[OP_SLT]  | d[OP_SLTI])                 c = 4'b1011;
    if (d[OP_SLTU] | d[OP_SLTIU])                c = 4'b1010;
    if (d[OP_SRA]  | d[OP_SRAV])                 c = 4'b1100;
    if (d[OP_SLL]  | d[OP_SLLV])                 c = 4'b1110;
    if (d[OP_SRL]  | d[OP_SRLV])                 c = 4'b1101;
    return c;
  endfunction

  // A malformed ir_op decodes to all-zero controls so it runs as a NOP.
  assign onehot = (ir_op != 31'd0) && ((ir_op & (ir_op - 31'd1)) == 31'd0);
  assign dec    = onehot ? ir_op : 31'd0;
  assign is_lw  = dec[OP_LW];
  assign is_sw  = dec[OP_SW];
  assign is_ctl = dec[OP_BEQ] | dec[OP_BNE] | dec[OP_J] | dec[OP_JR] | ~onehot;

  assign timeout = (MEM_TO != 0) && (cur == S_MEM) && !mem_ack &&
                   (wait_cnt == 32'(MEM_TO - 1));

  always_comb begin
    m_dec    = 9'd0;
    m_dec[0] = dec[OP_J] | dec[OP_JAL];
    m_dec[2] = dec[OP_JR];
    m_dec[3] = dec[OP_SLL] | dec[OP_SRL] | dec[OP_SRA];
    m_dec[4] = (|dec[OP_SRAV:OP_ADD]) | dec[OP_BEQ] | dec[OP_BNE];
    m_dec[5] = dec[OP_LW];
    m_dec[6] = dec[OP_ADDI] | dec[OP_ADDIU] | dec[OP_LW] | dec[OP_SW] |
               dec[OP_SLTI] | dec[OP_SLTIU] | dec[OP_BEQ] | dec[OP_BNE];
    m_dec[7] = dec[OP_JAL];
    m_dec[8] = |dec[OP_JR:OP_ADD];
  end

  always_comb begin
    im_r    = 1'b0;
    pc_we   = 1'b0;
    rf_we   = 1'b0;
    dm_cs   = 1'b0;
    dm_r    = 1'b0;
    dm_w    = 1'b0;
    illegal = 1'b0;
    mem_err = 1'b0;
    m       = m_dec;
    aluc    = alu_code(dec);
    if (cur == S_EX)
      m[1] = (dec[OP_BEQ] & zero) | (dec[OP_BNE] & ~zero);
    if (!rst) begin
      unique case (cur)
        S_IF:  im_r = 1'b1;
        S_ID:  illegal = ~onehot;
        S_EX:  pc_we = is_ctl & ~(is_lw | is_sw);
        S_MEM: begin
          dm_cs = 1'b1;
          dm_r  = is_lw;
          dm_w  = is_sw;
          if (mem_ack && is_sw) pc_we = 1'b1;
          if (timeout) begin
            mem_err = 1'b1;
            pc_we   = 1'b1;
          end
        end
        S_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
        end
        default: ;
      endcase
    end else begin
      m    = 9'd0;
      aluc = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= S_IF;
      ir_op    <= 31'd0;
      wait_cnt <= 32'd0;
      retired  <= '0;
    end else begin
      if (pc_we) retired <= retired + 1'b1;
      unique case (cur)
        S_IF: if (en) begin
          ir_op <= op;
          cur   <= S_ID;
        end
        S_ID: cur <= S_EX;
        S_EX: begin
          if (is_lw | is_sw) cur <= S_MEM;
          else if (is_ctl)   cur <= S_IF;
          else               cur <= S_WB;
        end
        S_MEM: begin
          if (mem_ack) begin
            wait_cnt <= 32'd0;
            cur      <= is_lw ? S_WB : S_IF;
          end else if (timeout) begin
            wait_cnt <= 32'd0;
            cur      <= S_IF;
          end else if (MEM_TO != 0) begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_WB:    cur <= S_IF;
        default: cur <= S_IF;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the driver pushes hand-computed per-cycle expectations,
// a monitor pops and compares them against the DUT outputs mid-cycle.
module tb_mc_control;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [30:0] op = 31'd0;
  logic        zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        im_r, pc_we, rf_we, dm_cs, dm_r, dm_w, illegal, mem_err;
  logic [8:0]  m;
  logic [3:0]  aluc;
  logic [2:0]  state;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  logic [55:0] exp_q[$];
  string       name_q[$];

  localparam logic [30:0] ADDU = 31'h0000_0002;
  localparam logic [30:0] SRA  = 31'h0000_1000;
  localparam logic [30:0] LW   = 31'h0040_0000;
  localparam logic [30:0] SW   = 31'h0080_0000;
  localparam logic [30:0] BEQ  = 31'h0100_0000;
  localparam logic [30:0] JAL  = 31'h4000_0000;
  localparam logic [30:0] BAD  = 31'h0000_0003;

  // strobe order: {im_r, pc_we, rf_we, dm_cs, dm_r, dm_w}
  localparam logic [5:0] NO  = 6'b000000;
  localparam logic [5:0] IM  = 6'b100000;
  localparam logic [5:0] PC  = 6'b010000;
  localparam logic [5:0] WB  = 6'b011000;
  localparam logic [5:0] RD  = 6'b000110;
  localparam logic [5:0] WR  = 6'b000101;
  localparam logic [5:0] WRP = 6'b010101;

  mc_control #(.RETIRE_W(32), .MEM_TO(4)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .zero(zero), .mem_ack(mem_ack),
    .im_r(im_r), .pc_we(pc_we), .rf_we(rf_we), .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w),
    .m(m), .aluc(aluc), .state(state), .retired(retired),
    .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string nm, input logic r, input logic e, input logic [30:0] o,
                     input logic z, input logic a, input logic [2:0] st, input logic [5:0] str,
                     input logic [8:0] mm, input logic [3:0] al, input logic [1:0] fl,
                     input logic [31:0] ret);
    @(posedge clk);
    #1;
    rst = r; en = e; op = o; zero = z; mem_ack = a;
    exp_q.push_back({st, str, mm, al, fl, ret});
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    logic [55:0] act;
    logic [55:0] exp;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {state, im_r, pc_we, rf_we, dm_cs, dm_r, dm_w, m, aluc, illegal, mem_err, retired};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL %s: got st=%0d str=%b m=%h aluc=%b ill/err=%b ret=%0d, want st=%0d str=%b m=%h aluc=%b ill/err=%b ret=%0d",
                   nm, act[55:53], act[52:47], act[46:38], act[37:34], act[33:32], act[31:0],
                   exp[55:53], exp[52:47], exp[46:38], exp[37:34], exp[33:32], exp[31:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    //   name          rst en op    z  ack st  str  m       aluc    fl     ret
    cyc("reset",       1, 0, 31'd0, 0, 0, 0, NO,  9'h000, 4'h0, 2'b00, 0);
    cyc("addu_if",     0, 1, ADDU,  0, 0, 0, IM,  9'h000, 4'h0, 2'b00, 0);
    cyc("addu_id",     0, 0, 31'd0, 0, 0, 1, NO,  9'h110, 4'h0, 2'b00, 0);
    cyc("addu_ex",     0, 0, 31'd0, 0, 0, 2, NO,  9'h110, 4'h0, 2'b00, 0);
    cyc("addu_wb",     0, 0, 31'd0, 0, 0, 4, WB,  9'h110, 4'h0, 2'b00, 0);
    cyc("addu_done",   0, 0, 31'd0, 0, 0, 0, IM,  9'h110, 4'h0, 2'b00, 1);
    cyc("en0_hold",    0, 0, ADDU,  0, 0, 0, IM,  9'h110, 4'h0, 2'b00, 1);
    cyc("addu2_if",    0, 1, ADDU,  0, 0, 0, IM,  9'h110, 4'h0, 2'b00, 1);
    cyc("addu2_id",    0, 0, 31'd0, 0, 0, 1, NO,  9'h110, 4'h0, 2'b00, 1);
    cyc("addu2_ex",    0, 0, 31'd0, 0, 0, 2, NO,  9'h110, 4'h0, 2'b00, 1);
    cyc("rst_mid_wb",  1, 0, 31'd0, 0, 0, 0, NO,  9'h000, 4'h0, 2'b00, 0);
    cyc("rst_release", 0, 0, 31'd0, 0, 0, 0, IM,  9'h000, 4'h0, 2'b00, 0);
    cyc("beq_if",      0, 1, BEQ,   0, 0, 0, IM,  9'h000, 4'h0, 2'b00, 0);
    cyc("beq_id",      0, 0, 31'd0, 0, 0, 1, NO,  9'h050, 4'h3, 2'b00, 0);
    cyc("beq_ex_z1",   0, 0, 31'd0, 1, 0, 2, PC,  9'h052, 4'h3, 2'b00, 0);
    cyc("beq2_if",     0, 1, BEQ,   0, 0, 0, IM,  9'h050, 4'h3, 2'b00, 1);
    cyc("beq2_id",     0, 0, 31'd0, 1, 0, 1, NO,  9'h050, 4'h3, 2'b00, 1);
    cyc("beq2_ex_z0",  0, 0, 31'd0, 0, 0, 2, PC,  9'h050, 4'h3, 2'b00, 1);
    cyc("lw_if",       0, 1, LW,    0, 0, 0, IM,  9'h050, 4'h3, 2'b00, 2);
    cyc("lw_id",       0, 0, 31'd0, 0, 0, 1, NO,  9'h060, 4'h0, 2'b00, 2);
    cyc("lw_ex",       0, 0, 31'd0, 0, 0, 2, NO,  9'h060, 4'h0, 2'b00, 2);
    cyc("lw_mem1",     0, 0, 31'd0, 0, 0, 3, RD,  9'h060, 4'h0, 2'b00, 2);
    cyc("lw_mem2",     0, 0, 31'd0, 0, 0, 3, RD,  9'h060, 4'h0, 2'b00, 2);
    cyc("lw_mem3",     0, 0, 31'd0, 0, 0, 3, RD,  9'h060, 4'h0, 2'b00, 2);
    cyc("lw_mem4_ack", 0, 0, 31'd0, 0, 1, 3, RD,  9'h060, 4'h0, 2'b00, 2);
    cyc("lw_wb",       0, 0, 31'd0, 0, 0, 4, WB,  9'h060, 4'h0, 2'b00, 2);
    cyc("sw_if",       0, 1, SW,    0, 0, 0, IM,  9'h060, 4'h0, 2'b00, 3);
    cyc("sw_id",       0, 0, 31'd0, 0, 0, 1, NO,  9'h040, 4'h0, 2'b00, 3);
    cyc("sw_ex",       0, 0, 31'd0, 0, 0, 2, NO,  9'h040, 4'h0, 2'b00, 3);
    cyc("sw_mem_ack",  0, 0, 31'd0, 0, 1, 3, WRP, 9'h040, 4'h0, 2'b00, 3);
    cyc("swto_if",     0, 1, SW,    0, 0, 0, IM,  9'h040, 4'h0, 2'b00, 4);
    cyc("swto_id",     0, 0, 31'd0, 0, 0, 1, NO,  9'h040, 4'h0, 2'b00, 4);
    cyc("swto_ex",     0, 0, 31'd0, 0, 0, 2, NO,  9'h040, 4'h0, 2'b00, 4);
    cyc("swto_mem1",   0, 0, 31'd0, 0, 0, 3, WR,  9'h040, 4'h0, 2'b00, 4);
    cyc("swto_mem2",   0, 0, 31'd0, 0, 0, 3, WR,  9'h040, 4'h0, 2'b00, 4);
    cyc("swto_mem3",   0, 0, 31'd0, 0, 0, 3, WR,  9'h040, 4'h0, 2'b00, 4);
    cyc("swto_mem4",   0, 0, 31'd0, 0, 0, 3, WRP, 9'h040, 4'h0, 2'b01, 4);
    cyc("bad_if",      0, 1, BAD,   0, 0, 0, IM,  9'h040, 4'h0, 2'b00, 5);
    cyc("bad_id",      0, 0, 31'd0, 0, 0, 1, NO,  9'h000, 4'h0, 2'b10, 5);
    cyc("bad_ex_nop",  0, 0, 31'd0, 1, 0, 2, PC,  9'h000, 4'h0, 2'b00, 5);
    cyc("sra_if",      0, 1, SRA,   0, 0, 0, IM,  9'h000, 4'h0, 2'b00, 6);
    cyc("sra_id",      0, 0, 31'd0, 0, 0, 1, NO,  9'h118, 4'hC, 2'b00, 6);
    cyc("sra_ex",      0, 0, 31'd0, 0, 0, 2, NO,  9'h118, 4'hC, 2'b00, 6);
    cyc("sra_wb",      0, 0, 31'd0, 0, 0, 4, WB,  9'h118, 4'hC, 2'b00, 6);
    cyc("jal_if",      0, 1, JAL,   0, 0, 0, IM,  9'h118, 4'hC, 2'b00, 7);
    cyc("jal_id",      0, 0, 31'd0, 0, 0, 1, NO,  9'h081, 4'h0, 2'b00, 7);
    cyc("jal_ex",      0, 0, 31'd0, 0, 0, 2, NO,  9'h081, 4'h0, 2'b00, 7);
    cyc("jal_wb",      0, 0, 31'd0, 0, 0, 4, WB,  9'h081, 4'h0, 2'b00, 7);
    cyc("final_if",    0, 0, 31'd0, 0, 0, 0, IM,  9'h081, 4'h0, 2'b00, 8);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
